// File: rtl/bti_mux_pkg.sv
// bti_pkg: shared types and constants for the BTI N-to-1 arbiter (bti_mux).
package bti_pkg;

  localparam int unsigned BTI_MAX_HOST_NUM  = 4;
  localparam int unsigned BTI_OST_DEPTH_DEF = 4;

  typedef logic [1:0] bti_host_id_t;

  // Grant lock: HELD while the guest is stalling the current winner.
  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } bti_lock_e;

  // Next host index after id, wrapping at num.
  function automatic bti_host_id_t bti_next_host(bti_host_id_t id, int unsigned num);
    if (32'(id) + 32'd1 >= num) return '0;
    return id + 2'd1;
  endfunction

endpackage

// File: rtl/bti_mux_if.sv
// BTI request and response channel interfaces (vld/rdy handshake).
interface bti_req_if_t #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic            vld;
  logic            rdy;
  logic [AW-1:0]   addr;
  logic            wr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;

  modport master (output vld, addr, wr, wdata, wstrb, input rdy);
  modport slave  (input vld, addr, wr, wdata, wstrb, output rdy);
endinterface

interface bti_rsp_if_t #(
  parameter int unsigned DW = 32
);
  logic          vld;
  logic          rdy;
  logic [DW-1:0] data;

  modport master (output vld, data, input rdy);
  modport slave  (input vld, data, output rdy);
endinterface

// File: rtl/bti_mux_ost_fifo.sv
// bti_ost_fifo: synchronous FIFO of host IDs for outstanding BTI requests.
// Pointers wrap naturally; count has one extra bit to tell full from empty.
module bti_ost_fifo
  import bti_pkg::*;
#(
  parameter int unsigned DEPTH = BTI_OST_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  bti_host_id_t push_id_i,
  input  logic         pop_i,
  output bti_host_id_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  bti_host_id_t  mem_q [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Next pointers and occupancy; simultaneous push and pop keep the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage; contents are qualified by the count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_id_i;
  end

endmodule

// File: rtl/bti_mux.sv
// bti_mux: merges HOST_NUM BTI hosts onto one guest port. Round-robin grant
// with a stall lock; responses are routed back in order via an ID FIFO.
// Optional macro BTI_MUX_FIXED_PRIO_EN: fixed priority, host 0 highest.
module bti_mux
  import bti_pkg::*;
#(
  parameter int unsigned BTI_AW    = 32,
  parameter int unsigned BTI_DW    = 32,
  parameter int unsigned HOST_NUM  = 2,
  parameter int unsigned OST_DEPTH = BTI_OST_DEPTH_DEF
) (
  input logic         clk,
  input logic         rst_n,
  bti_req_if_t.slave  host_bti_req_slvs [HOST_NUM],
  bti_rsp_if_t.master host_bti_rsp_msts [HOST_NUM],
  bti_req_if_t.master gst_bti_req_mst,
  bti_rsp_if_t.slave  gst_bti_rsp_slv
);

  // Host-side signals padded to BTI_MAX_HOST_NUM so a host ID indexes exactly.
  logic [BTI_MAX_HOST_NUM-1:0] host_vld;
  logic [BTI_MAX_HOST_NUM-1:0] host_rsp_rdy;
  logic [BTI_AW-1:0]           host_addr  [BTI_MAX_HOST_NUM];
  logic                        host_wr    [BTI_MAX_HOST_NUM];
  logic [BTI_DW-1:0]           host_wdata [BTI_MAX_HOST_NUM];
  logic [BTI_DW/8-1:0]         host_wstrb [BTI_MAX_HOST_NUM];

  bti_lock_e    lock_st_q;
  bti_host_id_t lock_id_q;
  bti_host_id_t win_id;
  bti_host_id_t cand_id;
  logic         found;
  logic         any_req;
  logic         gnt_en;
  logic         gst_vld;
  logic         req_hs;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_pop;
  bti_host_id_t head_id;
  int unsigned  cand_idx;

  for (genvar g = 0; g < BTI_MAX_HOST_NUM; g++) begin : g_host
    if (g < HOST_NUM) begin : g_used
      assign host_vld[g]     = host_bti_req_slvs[g].vld;
      assign host_addr[g]    = host_bti_req_slvs[g].addr;
      assign host_wr[g]      = host_bti_req_slvs[g].wr;
      assign host_wdata[g]   = host_bti_req_slvs[g].wdata;
      assign host_wstrb[g]   = host_bti_req_slvs[g].wstrb;
      assign host_rsp_rdy[g] = host_bti_rsp_msts[g].rdy;
      assign host_bti_req_slvs[g].rdy  = gnt_en & (win_id == bti_host_id_t'(g))
                                         & gst_bti_req_mst.rdy;
      assign host_bti_rsp_msts[g].vld  = ~fifo_empty & gst_bti_rsp_slv.vld
                                         & (head_id == bti_host_id_t'(g));
      assign host_bti_rsp_msts[g].data = gst_bti_rsp_slv.data;
    end else begin : g_pad
      assign host_vld[g]     = 1'b0;
      assign host_addr[g]    = '0;
      assign host_wr[g]      = 1'b0;
      assign host_wdata[g]   = '0;
      assign host_wstrb[g]   = '0;
      assign host_rsp_rdy[g] = 1'b0;
    end
  end

`ifdef BTI_MUX_FIXED_PRIO_EN
  // Winner: locked host, else the lowest-index requester.
  always_comb begin
    any_req  = |host_vld;
    win_id   = '0;
    found    = 1'b0;
    cand_idx = 0;
    cand_id  = '0;
    if (lock_st_q == LOCK_HELD) begin
      win_id = lock_id_q;
    end else begin
      for (int unsigned k = 0; k < HOST_NUM; k++) begin
        cand_idx = k;
        cand_id  = bti_host_id_t'(cand_idx);
        if (!found && host_vld[cand_id]) begin
          win_id = cand_id;
          found  = 1'b1;
        end
      end
    end
  end
`else
  bti_host_id_t rr_ptr_q;

  // Winner: locked host, else first requester at or after rr_ptr (cyclic).
  always_comb begin
    any_req  = |host_vld;
    win_id   = rr_ptr_q;
    found    = 1'b0;
    cand_idx = 0;
    cand_id  = '0;
    if (lock_st_q == LOCK_HELD) begin
      win_id = lock_id_q;
    end else begin
      for (int unsigned k = 0; k < HOST_NUM; k++) begin
        cand_idx = 32'(rr_ptr_q) + k;
        if (cand_idx >= HOST_NUM) cand_idx = cand_idx - HOST_NUM;
        cand_id = bti_host_id_t'(cand_idx);
        if (!found && host_vld[cand_id]) begin
          win_id = cand_id;
          found  = 1'b1;
        end
      end
    end
  end

  // Round-robin pointer moves past the winner on each accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr_ptr_q <= '0;
    else if (req_hs) rr_ptr_q <= bti_next_host(win_id, HOST_NUM);
  end
`endif

  // A full ID FIFO blocks the grant outright; a same-cycle pop does not help.
  assign gnt_en  = ~fifo_full & ((lock_st_q == LOCK_HELD) | any_req);
  assign gst_vld = gnt_en & host_vld[win_id];
  assign req_hs  = gst_vld & gst_bti_req_mst.rdy;

  assign gst_bti_req_mst.vld   = gst_vld;
  assign gst_bti_req_mst.addr  = host_addr[win_id];
  assign gst_bti_req_mst.wr    = host_wr[win_id];
  assign gst_bti_req_mst.wdata = host_wdata[win_id];
  assign gst_bti_req_mst.wstrb = host_wstrb[win_id];

  // Lock the winner while the guest stalls; release on the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_st_q <= LOCK_IDLE;
      lock_id_q <= '0;
    end else begin
      case (lock_st_q)
        LOCK_IDLE: begin
          if (gst_vld && !gst_bti_req_mst.rdy) begin
            lock_st_q <= LOCK_HELD;
            lock_id_q <= win_id;
          end
        end
        LOCK_HELD: begin
          if (req_hs) lock_st_q <= LOCK_IDLE;
        end
        default: lock_st_q <= LOCK_IDLE;
      endcase
    end
  end

  // With no outstanding ID, a stray response is accepted and discarded.
  assign gst_bti_rsp_slv.rdy = fifo_empty ? gst_bti_rsp_slv.vld : host_rsp_rdy[head_id];
  assign fifo_pop            = ~fifo_empty & gst_bti_rsp_slv.vld & host_rsp_rdy[head_id];

  bti_ost_fifo #(
    .DEPTH (OST_DEPTH)
  ) u_ost_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (req_hs),
    .push_id_i (win_id),
    .pop_i     (fifo_pop),
    .head_o    (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

endmodule

// File: tb/tb_bti_mux.sv
// Testbench for bti_mux: two hosts, depth-4 ID FIFO, directed stimulus with
// a queue-based reference model checked every cycle plus literal checks.
module tb_bti_mux;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;

  logic        h_vld   [2];
  logic [31:0] h_addr  [2];
  logic        h_wr    [2];
  logic [31:0] h_wdata [2];
  logic [3:0]  h_wstrb [2];
  logic        h_rrdy  [2];
  logic        h_rdy   [2];
  logic        r_vld   [2];
  logic [31:0] r_data  [2];
  logic        g_rdy;
  logic        g_rvld;
  logic [31:0] g_rdata;

  int n_pass  = 0;
  int n_total = 0;

  bti_req_if_t #(.AW(32), .DW(32)) host_req [2] ();
  bti_rsp_if_t #(.DW(32))          host_rsp [2] ();
  bti_req_if_t #(.AW(32), .DW(32)) gst_req ();
  bti_rsp_if_t #(.DW(32))          gst_rsp ();

  for (genvar g = 0; g < 2; g++) begin : g_tb_host
    assign host_req[g].vld   = h_vld[g];
    assign host_req[g].addr  = h_addr[g];
    assign host_req[g].wr    = h_wr[g];
    assign host_req[g].wdata = h_wdata[g];
    assign host_req[g].wstrb = h_wstrb[g];
    assign h_rdy[g]          = host_req[g].rdy;
    assign host_rsp[g].rdy   = h_rrdy[g];
    assign r_vld[g]          = host_rsp[g].vld;
    assign r_data[g]         = host_rsp[g].data;
  end

  assign gst_req.rdy  = g_rdy;
  assign gst_rsp.vld  = g_rvld;
  assign gst_rsp.data = g_rdata;

  bti_mux #(
    .BTI_AW    (32),
    .BTI_DW    (32),
    .HOST_NUM  (2),
    .OST_DEPTH (DEPTH)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .host_bti_req_slvs (host_req),
    .host_bti_rsp_msts (host_rsp),
    .gst_bti_req_mst   (gst_req),
    .gst_bti_rsp_slv   (gst_rsp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Reference model: outstanding host IDs in a queue, rr pointer, lock.
  int mq[$];
  int m_rr    = 0;
  bit m_lk    = 0;
  int m_lk_id = 0;

  always @(negedge clk) begin : model
    int   win;
    int   c;
    bit   full;
    bit   emp;
    logic e_gvld;
    logic e_grrdy;
    logic e_hrdy [2];
    logic e_rvld [2];
    if (!rst_n) begin
      mq.delete();
      m_rr    = 0;
      m_lk    = 0;
      m_lk_id = 0;
    end
    full = (mq.size() == DEPTH);
    emp  = (mq.size() == 0);
    win  = -1;
    if (!full) begin
      if (m_lk) win = m_lk_id;
      else begin
        for (int k = 0; k < 2; k++) begin
          c = (m_rr + k) % 2;
          if (win < 0 && h_vld[c]) win = c;
        end
      end
    end
    e_gvld = (win >= 0) ? h_vld[win] : 1'b0;
    for (int h = 0; h < 2; h++) begin
      e_hrdy[h] = (win == h) && g_rdy;
      e_rvld[h] = !emp && g_rvld && (mq[0] == h);
    end
    if (emp) e_grrdy = g_rvld;
    else     e_grrdy = h_rrdy[mq[0]];

    chk("m_gvld", 32'(gst_req.vld), 32'(e_gvld));
    chk("m_grrdy", 32'(gst_rsp.rdy), 32'(e_grrdy));
    for (int h = 0; h < 2; h++) begin
      chk($sformatf("m_hrdy%0d", h), 32'(h_rdy[h]), 32'(e_hrdy[h]));
      chk($sformatf("m_rvld%0d", h), 32'(r_vld[h]), 32'(e_rvld[h]));
      if (e_rvld[h]) chk($sformatf("m_rdata%0d", h), r_data[h], g_rdata);
    end
    if (e_gvld) begin
      chk("m_addr", gst_req.addr, h_addr[win]);
      chk("m_wr", 32'(gst_req.wr), 32'(h_wr[win]));
      chk("m_wdata", gst_req.wdata, h_wdata[win]);
      chk("m_wstrb", 32'(gst_req.wstrb), 32'(h_wstrb[win]));
    end

    if (rst_n) begin
      if (!emp && g_rvld && e_grrdy) void'(mq.pop_front());
      if (e_gvld && g_rdy) begin
        mq.push_back(win);
        m_rr = (win + 1) % 2;
        m_lk = 0;
      end else if (e_gvld && !g_rdy) begin
        m_lk    = 1;
        m_lk_id = win;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic set_host(input int h, input logic v, input logic [31:0] a,
                          input logic w, input logic [31:0] d);
    h_vld[h]   = v;
    h_addr[h]  = a;
    h_wr[h]    = w;
    h_wdata[h] = d;
    h_wstrb[h] = w ? 4'hF : 4'h0;
  endtask

  int exp_seq [4] = '{0, 1, 0, 1};

  initial begin
    rst_n = 1'b0;
    for (int h = 0; h < 2; h++) begin
      set_host(h, 1'b0, 32'h0, 1'b0, 32'h0);
      h_rrdy[h] = 1'b0;
    end
    g_rdy   = 1'b0;
    g_rvld  = 1'b0;
    g_rdata = 32'h0;

    // Reset values
    look();
    chk("rst_gvld", 32'(gst_req.vld), 32'd0);
    chk("rst_hrdy0", 32'(h_rdy[0]), 32'd0);
    chk("rst_hrdy1", 32'(h_rdy[1]), 32'd0);
    chk("rst_rvld0", 32'(r_vld[0]), 32'd0);
    chk("rst_rvld1", 32'(r_vld[1]), 32'd0);
    chk("rst_grrdy", 32'(gst_rsp.rdy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single host: host1 reads 0x100, response two cycles later
    set_host(1, 1'b1, 32'h100, 1'b0, 32'h0);
    g_rdy = 1'b1;
    look();
    chk("t1_gvld", 32'(gst_req.vld), 32'd1);
    chk("t1_addr", gst_req.addr, 32'h100);
    chk("t1_hrdy1", 32'(h_rdy[1]), 32'd1);
    chk("t1_hrdy0", 32'(h_rdy[0]), 32'd0);
    tick();
    h_vld[1] = 1'b0;
    tick();
    g_rvld    = 1'b1;
    g_rdata   = 32'hCAFE0001;
    h_rrdy[1] = 1'b1;
    look();
    chk("t1_rvld1", 32'(r_vld[1]), 32'd1);
    chk("t1_rdata1", r_data[1], 32'hCAFE0001);
    chk("t1_rvld0", 32'(r_vld[0]), 32'd0);
    chk("t1_grrdy", 32'(gst_rsp.rdy), 32'd1);
    tick();
    g_rvld = 1'b0;

    // Round-robin: both hosts request for four cycles
    set_host(0, 1'b1, 32'h1000, 1'b1, 32'h11);
    set_host(1, 1'b1, 32'h2000, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      look();
      chk($sformatf("rr_hrdy0_%0d", i), 32'(h_rdy[0]), 32'(exp_seq[i] == 0));
      chk($sformatf("rr_hrdy1_%0d", i), 32'(h_rdy[1]), 32'(exp_seq[i] == 1));
      chk($sformatf("rr_addr_%0d", i), gst_req.addr, (exp_seq[i] == 1) ? 32'h2000 : 32'h1000);
      tick();
    end
    h_vld[0]  = 1'b0;
    h_vld[1]  = 1'b0;
    h_rrdy[0] = 1'b1;
    h_rrdy[1] = 1'b1;
    g_rvld    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      g_rdata = 32'hD0 + 32'(i);
      look();
      chk($sformatf("rr_rvld0_%0d", i), 32'(r_vld[0]), 32'(exp_seq[i] == 0));
      chk($sformatf("rr_rvld1_%0d", i), 32'(r_vld[1]), 32'(exp_seq[i] == 1));
      tick();
    end
    g_rvld = 1'b0;

    // Stall lock: move rr_ptr to host1 first so the lock is what keeps host0
    set_host(0, 1'b1, 32'h50, 1'b0, 32'h0);
    tick();
    h_vld[0] = 1'b0;
    g_rvld   = 1'b1;
    g_rdata  = 32'h55;
    tick();
    g_rvld = 1'b0;
    g_rdy  = 1'b0;
    set_host(0, 1'b1, 32'h200, 1'b1, 32'hA5A5);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) set_host(1, 1'b1, 32'h300, 1'b0, 32'h0);
      look();
      chk($sformatf("lk_addr_%0d", i), gst_req.addr, 32'h200);
      chk($sformatf("lk_hrdy1_%0d", i), 32'(h_rdy[1]), 32'd0);
      tick();
    end
    g_rdy = 1'b1;
    look();
    chk("lk_rel_addr", gst_req.addr, 32'h200);
    chk("lk_rel_hrdy0", 32'(h_rdy[0]), 32'd1);
    tick();
    h_vld[0] = 1'b0;
    look();
    chk("lk_next_addr", gst_req.addr, 32'h300);
    chk("lk_next_hrdy1", 32'(h_rdy[1]), 32'd1);
    tick();
    h_vld[1] = 1'b0;
    g_rvld   = 1'b1;
    g_rdata  = 32'h77;
    tick();
    tick();
    g_rvld = 1'b0;

    // FIFO full: four accepted, fifth stalls until one cycle after a pop
    set_host(0, 1'b1, 32'h400, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    h_vld[0] = 1'b0;
    set_host(1, 1'b1, 32'h500, 1'b1, 32'h5A5A);
    look();
    chk("ff_gvld", 32'(gst_req.vld), 32'd0);
    chk("ff_hrdy0", 32'(h_rdy[0]), 32'd0);
    chk("ff_hrdy1", 32'(h_rdy[1]), 32'd0);
    tick();
    g_rvld  = 1'b1;
    g_rdata = 32'hE0;
    look();
    chk("ff_pop_gvld", 32'(gst_req.vld), 32'd0);
    chk("ff_pop_hrdy1", 32'(h_rdy[1]), 32'd0);
    chk("ff_pop_rvld0", 32'(r_vld[0]), 32'd1);
    tick();
    g_rvld = 1'b0;
    look();
    chk("ff_acc_hrdy1", 32'(h_rdy[1]), 32'd1);
    chk("ff_acc_addr", gst_req.addr, 32'h500);
    tick();
    h_vld[1] = 1'b0;

    // Response backpressure: host0 holds rsp rdy low for two cycles
    h_rrdy[0] = 1'b0;
    g_rvld    = 1'b1;
    g_rdata   = 32'hF0;
    for (int i = 0; i < 2; i++) begin
      look();
      chk($sformatf("bp_grrdy_%0d", i), 32'(gst_rsp.rdy), 32'd0);
      chk($sformatf("bp_rvld0_%0d", i), 32'(r_vld[0]), 32'd1);
      tick();
    end
    h_rrdy[0] = 1'b1;
    look();
    chk("bp_grrdy_go", 32'(gst_rsp.rdy), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      g_rdata = 32'hF1 + 32'(i);
      look();
      chk($sformatf("bp_drain_rvld1_%0d", i), 32'(r_vld[1]), 32'(i == 2));
      tick();
    end
    g_rvld = 1'b0;

    // Reset mid-flight with two outstanding requests
    set_host(0, 1'b1, 32'h600, 1'b0, 32'h0);
    tick();
    tick();
    h_vld[0] = 1'b0;
    rst_n    = 1'b0;
    look();
    chk("rm_gvld", 32'(gst_req.vld), 32'd0);
    chk("rm_hrdy0", 32'(h_rdy[0]), 32'd0);
    chk("rm_hrdy1", 32'(h_rdy[1]), 32'd0);
    chk("rm_rvld0", 32'(r_vld[0]), 32'd0);
    chk("rm_grrdy", 32'(gst_rsp.rdy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    g_rvld  = 1'b1;
    g_rdata = 32'hBAD;
    look();
    chk("rm_stray_grrdy", 32'(gst_rsp.rdy), 32'd1);
    chk("rm_stray_rvld0", 32'(r_vld[0]), 32'd0);
    chk("rm_stray_rvld1", 32'(r_vld[1]), 32'd0);
    tick();
    g_rvld = 1'b0;
    set_host(0, 1'b1, 32'h800, 1'b0, 32'h0);
    set_host(1, 1'b1, 32'h900, 1'b0, 32'h0);
    look();
    chk("rm_rr_hrdy0", 32'(h_rdy[0]), 32'd1);
    chk("rm_rr_addr", gst_req.addr, 32'h800);
    tick();
    h_vld[0] = 1'b0;
    h_vld[1] = 1'b0;
    g_rvld   = 1'b1;
    g_rdata  = 32'h88;
    tick();
    g_rvld = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
